// File: rtl/dist_mem_reader_if.sv
// dist_mem_reader_if: command, memory-read and beat-stream signals of dist_mem_reader (DIST_MIN_EN adds min outputs)
interface dist_mem_reader_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 3
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] startAddr;
  logic [ADDR_WIDTH-1:0] numPairs;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] readAddr;
  logic [WIDTH-1:0]      inaDist, inbDist, incDist, indDist;
  logic [WIDTH-1:0]      outaDist, outbDist, outcDist, outdDist;
  logic                  outValid;
  logic                  outReady;
  logic                  outLast;
  logic [ADDR_WIDTH-1:0] outAddr;
`ifdef DIST_MIN_EN
  logic [WIDTH-1:0]      outMinDist;
  logic [1:0]            outMinIdx;
`endif
  modport slave (
    input  start, startAddr, numPairs, inaDist, inbDist, incDist, indDist, outReady,
    output busy, done, readAddr, outaDist, outbDist, outcDist, outdDist, outValid, outLast, outAddr
`ifdef DIST_MIN_EN
    , output outMinDist, outMinIdx
`endif
  );
  modport master (
    output start, startAddr, numPairs, inaDist, inbDist, incDist, indDist, outReady,
    input  busy, done, readAddr, outaDist, outbDist, outcDist, outdDist, outValid, outLast, outAddr
`ifdef DIST_MIN_EN
    , input outMinDist, outMinIdx
`endif
  );
endinterface

// File: rtl/dist_mem_reader.sv
// dist_mem_reader: walks address pairs of the two-bank distance memory and streams 4-lane beats (DIST_MIN_EN adds lane min/index)
module dist_mem_reader #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 8
) (
  input logic              clk,
  input logic              rst_n,
  dist_mem_reader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic [WIDTH-1:0]      a, b, c, d;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  last;
`ifdef DIST_MIN_EN
    logic [WIDTH-1:0]      mn;
    logic [1:0]            idx;
`endif
  } beat_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, rem_q, if_addr_q;
  logic                  if_q, if_last_q, done_q, done_d;
  logic                  wr_q, rd_q;
  logic [1:0]            cnt_q, occ;
  beat_t                 mem_q [2];
  beat_t                 beat, head;
  logic                  launch, push, pop, issue, fin;
  assign launch = state_q == IDLE && bus.start && bus.numPairs != '0;
  assign push   = if_q;
  assign pop    = cnt_q != 2'd0 && bus.outReady;
  // credit counts the slot freed by this cycle's pop so a steady stream runs at 1 beat/clk
  assign occ    = cnt_q - {1'b0, pop} + {1'b0, if_q};
  assign issue  = state_q == RUN && occ < 2'd2;
  assign fin    = state_q == DRAIN && !if_q && cnt_q == {1'b0, pop};
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (launch) state_d = RUN;
        done_d = bus.start && bus.numPairs == '0;
      end
      RUN: if (issue && rem_q == ADDR_WIDTH'(1)) state_d = DRAIN;
      DRAIN: if (fin) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
`ifdef DIST_MIN_EN
  logic [WIDTH-1:0] ab, cd;
  logic             ab_sel, cd_sel, cd_win;
  assign ab_sel = bus.inbDist < bus.inaDist;
  assign cd_sel = bus.indDist < bus.incDist;
  assign ab     = ab_sel ? bus.inbDist : bus.inaDist;
  assign cd     = cd_sel ? bus.indDist : bus.incDist;
  assign cd_win = cd < ab;
`endif
  always_comb begin
    beat      = '0;
    beat.a    = bus.inaDist;
    beat.b    = bus.inbDist;
    beat.c    = bus.incDist;
    beat.d    = bus.indDist;
    beat.addr = if_addr_q;
    beat.last = if_last_q;
`ifdef DIST_MIN_EN
    beat.mn   = cd_win ? cd : ab;
    beat.idx  = cd_win ? {1'b1, cd_sel} : {1'b0, ab_sel};
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      addr_q    <= '0;
      rem_q     <= '0;
      if_q      <= 1'b0;
      if_last_q <= 1'b0;
      if_addr_q <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      cnt_q     <= 2'd0;
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (launch) begin
        addr_q <= bus.startAddr & ~ADDR_WIDTH'(1);
        rem_q  <= bus.numPairs;
      end else if (issue) begin
        addr_q <= ADDR_WIDTH'((int'(addr_q) + 2) % DEPTH);
        rem_q  <= rem_q - ADDR_WIDTH'(1);
      end
      if_q <= issue;
      if (issue) begin
        if_addr_q <= addr_q;
        if_last_q <= rem_q == ADDR_WIDTH'(1);
      end
      if (push) begin
        mem_q[wr_q] <= beat;
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end
  assign head         = mem_q[rd_q];
  assign bus.busy     = state_q != IDLE;
  assign bus.done     = done_q;
  assign bus.readAddr = addr_q;
  assign bus.outValid = cnt_q != 2'd0;
  assign bus.outLast  = bus.outValid && head.last;
  assign bus.outAddr  = head.addr;
  assign bus.outaDist = head.a;
  assign bus.outbDist = head.b;
  assign bus.outcDist = head.c;
  assign bus.outdDist = head.d;
`ifdef DIST_MIN_EN
  assign bus.outMinDist = head.mn;
  assign bus.outMinIdx  = head.idx;
`endif
endmodule

// File: tb/tb_dist_mem_reader.sv
// tb_dist_mem_reader: directed checks of dist_mem_reader against a registered two-bank memory model
module tb_dist_mem_reader;
  logic clk, rst_n;
  bit   force_lanes;
  int   n_assert, n_fail;
  int   nb, issued, acc, done_c;
  bit   done_seen, busy_seen, valid_seen;
  logic [2:0]  g_addr [8];
  logic [15:0] g_a [8], g_b [8], g_c_ [8], g_d [8];
  logic        g_last [8];
  int          g_cyc [8];
  dist_mem_reader_if #(.WIDTH(16), .ADDR_WIDTH(3)) bus ();
  dist_mem_reader #(.WIDTH(16), .ADDR_WIDTH(3), .DEPTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // bank0 word k = 10k, bank1 word k = 10k+5, one-clock registered read
  always_ff @(posedge clk) begin
    bus.inaDist <= force_lanes ? 16'd40 : 16'(bus.readAddr) * 16'd10;
    bus.inbDist <= force_lanes ? 16'd12 : 16'(3'(bus.readAddr + 3'd1)) * 16'd10;
    bus.incDist <= force_lanes ? 16'd12 : 16'(bus.readAddr) * 16'd10 + 16'd5;
    bus.indDist <= force_lanes ? 16'd90 : 16'(3'(bus.readAddr + 3'd1)) * 16'd10 + 16'd5;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic run_job(input logic [2:0] sa, input int np, input int mode);
    logic [2:0]  prev_ra, h_addr;
    logic [15:0] h_a;
    logic        h_last;
    bit          held;
    nb = 0; issued = 0; acc = 0; done_c = -1;
    done_seen = 0; busy_seen = 0; valid_seen = 0; held = 0;
    prev_ra = '0; h_addr = '0; h_a = '0; h_last = 0;
    bus.startAddr = sa;
    bus.numPairs  = 3'(np);
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      bus.outReady = (mode == 0) || (c % 3 == 0);
      if (c == 0) begin
        chk("busy_after_start", 32'(bus.busy), 32'(np != 0));
        if (np != 0) chk("ra_start", 32'(bus.readAddr), 32'(sa & 3'b110));
      end else if (bus.readAddr !== prev_ra) begin
        chk("issue_credit", 32'((issued - acc) < 2), 32'd1);
        issued++;
      end
      prev_ra = bus.readAddr;
      if (held) begin
        chk("hold_valid", 32'(bus.outValid), 32'd1);
        chk("hold_addr", 32'(bus.outAddr), 32'(h_addr));
        chk("hold_a", 32'(bus.outaDist), 32'(h_a));
        chk("hold_last", 32'(bus.outLast), 32'(h_last));
      end
      busy_seen  |= bus.busy;
      valid_seen |= bus.outValid;
      if (bus.outValid && bus.outReady) begin
        if (nb < 8) begin
          g_addr[nb] = bus.outAddr; g_a[nb] = bus.outaDist; g_b[nb] = bus.outbDist;
          g_c_[nb] = bus.outcDist; g_d[nb] = bus.outdDist; g_last[nb] = bus.outLast; g_cyc[nb] = c;
        end
        nb++;
        acc++;
      end
      held = bus.outValid && !bus.outReady;
      h_addr = bus.outAddr; h_a = bus.outaDist; h_last = bus.outLast;
      if (bus.done) begin
        done_seen = 1; done_c = c;
        chk("busy_at_done", 32'(bus.busy), 32'd0);
        chk("valid_at_done", 32'(bus.outValid), 32'd0);
      end
      @(negedge clk);
      if (done_seen) break;
    end
    chk("done_seen", 32'(done_seen), 32'd1);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
  endtask
  task automatic check_job(input logic [2:0] sa, input int np, input int mode);
    logic [2:0] ad, ad1;
    ad = sa & 3'b110;
    chk("beat_count", 32'(nb), 32'(np));
    chk("issued", 32'(issued), 32'(np));
    for (int k = 0; k < np && k < nb && k < 8; k++) begin
      ad1 = ad + 3'd1;
      chk("beat_addr", 32'(g_addr[k]), 32'(ad));
      chk("beat_a", 32'(g_a[k]), 32'(ad) * 10);
      chk("beat_b", 32'(g_b[k]), 32'(ad1) * 10);
      chk("beat_c", 32'(g_c_[k]), 32'(ad) * 10 + 5);
      chk("beat_d", 32'(g_d[k]), 32'(ad1) * 10 + 5);
      chk("beat_last", 32'(g_last[k]), 32'(k == np - 1));
      ad = ad + 3'd2;
    end
    if (np == 0) begin
      chk("done_at_zero", 32'(done_c), 32'd0);
      chk("busy_seen_zero", 32'(busy_seen), 32'd0);
      chk("valid_seen_zero", 32'(valid_seen), 32'd0);
    end else if (nb == np) begin
      chk("done_after_last", 32'(done_c), 32'(g_cyc[np-1] + 1));
      if (mode == 0) begin
        chk("first_beat_cycle", 32'(g_cyc[0]), 32'd2);
        chk("last_beat_cycle", 32'(g_cyc[np-1]), 32'(np + 1));
      end
    end
  endtask
  initial begin
    n_assert = 0; n_fail = 0; force_lanes = 0;
    rst_n = 1'b0; bus.start = 1'b0; bus.startAddr = '0; bus.numPairs = '0; bus.outReady = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_valid", 32'(bus.outValid), 32'd0);
    chk("rst_last", 32'(bus.outLast), 32'd0);
    chk("rst_readaddr", 32'(bus.readAddr), 32'd0);
    chk("rst_outaddr", 32'(bus.outAddr), 32'd0);
    chk("rst_outa", 32'(bus.outaDist), 32'd0);
    chk("rst_outd", 32'(bus.outdDist), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_job(3'd0, 4, 0); check_job(3'd0, 4, 0);
    run_job(3'd6, 3, 0); check_job(3'd6, 3, 0);
    run_job(3'd0, 4, 1); check_job(3'd0, 4, 1);
    run_job(3'd0, 0, 0); check_job(3'd0, 0, 0);
    run_job(3'd3, 2, 0); check_job(3'd3, 2, 0);
    run_job(3'd2, 7, 1); check_job(3'd2, 7, 1);
    // second start mid-job is ignored, then reset aborts the job after beat 2
    bus.outReady = 1'b1; bus.startAddr = 3'd2; bus.numPairs = 3'd4; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.startAddr = 3'd4; bus.numPairs = 3'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("abort_b1_valid", 32'(bus.outValid), 32'd1);
    chk("abort_b1_addr", 32'(bus.outAddr), 32'd2);
    @(negedge clk);
    chk("abort_b2_addr", 32'(bus.outAddr), 32'd4);
    chk("abort_b2_busy", 32'(bus.busy), 32'd1);
    chk("abort_b2_last", 32'(bus.outLast), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(bus.outValid), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_readaddr", 32'(bus.readAddr), 32'd0);
    chk("abort_outaddr", 32'(bus.outAddr), 32'd0);
    chk("abort_outb", 32'(bus.outbDist), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_done", 32'(bus.done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle_done", 32'(bus.done), 32'd0);
    run_job(3'd4, 2, 0); check_job(3'd4, 2, 0);
`ifdef DIST_MIN_EN
    force_lanes = 1;
    bus.outReady = 1'b0; bus.startAddr = 3'd0; bus.numPairs = 3'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("min_valid", 32'(bus.outValid), 32'd1);
    chk("min_dist", 32'(bus.outMinDist), 32'd12);
    chk("min_idx", 32'(bus.outMinIdx), 32'd1);
    bus.outReady = 1'b1;
    repeat (3) @(negedge clk);
    force_lanes = 0;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
